// File: rtl/side_buffer_ctrl_if.sv
// Handshake/bus bundle between the MinBD side-buffer controller and its neighbours.
// master = router-side driver (eject/injection stages), slave = side_buffer_ctrl.
interface side_buffer_ctrl_if #(
    parameter int FLIT_W = 11
);
    logic              defl_valid;
    logic [FLIT_W-1:0] defl_flit;
    logic              defl_ack;
    logic              slot_free;
    logic              chan_valid;
    logic [FLIT_W-1:0] chan_flit;
    logic              inject;
    logic [FLIT_W-1:0] inj_flit;
    logic              redirect;
    logic [3:0]        count;
    logic              full;
    logic              empty;

    modport master (
        output defl_valid, defl_flit, slot_free, chan_valid, chan_flit,
        input  defl_ack, inject, inj_flit, redirect, count, full, empty
    );
    modport slave (
        input  defl_valid, defl_flit, slot_free, chan_valid, chan_flit,
        output defl_ack, inject, inj_flit, redirect, count, full, empty
    );
endinterface

// File: rtl/side_buffer_ctrl.sv
// MinBD side-buffer controller: captures deflected flits, re-injects into free slots, forces swaps on starvation.
// Optional SB_RANDOM_CAPTURE_EN: LFSR-gated (~50%) probabilistic capture.
module side_buffer_ctrl #(
    parameter int FLIT_W     = 11,
    parameter int DEPTH      = 6,
    parameter int STARVE_LIM = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    side_buffer_ctrl_if.slave  sb
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REDIRECT} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [7:0]        starve_q, starve_d;
    logic              inject_q, redirect_q;
    logic [FLIT_W-1:0] inj_flit_q;
    logic [FLIT_W-1:0] mem_q [DEPTH];

    logic full, empty, force_redir, cap_ok, ack, rein, swap, pop, wr_en;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == 4'(DEPTH));
    assign empty = (cnt_q == 4'd0);

`ifdef SB_RANDOM_CAPTURE_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign cap_ok = ~lfsr_q[0];
`else
    assign cap_ok = 1'b1;
`endif

    // Output/control decode. A saturated starve counter blocks capture in the same cycle.
    always_comb begin
        force_redir = (state_q == S_HOLD) && (starve_q == LIM);
        ack   = sb.defl_valid && !full && (state_q != S_REDIRECT) && !force_redir && cap_ok;
        rein  = !empty && sb.slot_free;
        swap  = (state_q == S_REDIRECT) && !sb.slot_free && sb.chan_valid;
        pop   = rein || swap;
        wr_en = ack || swap;
        cnt_d = cnt_q + 4'(ack) - 4'(rein);
        wr_d  = wr_en ? nxt(wr_q) : wr_q;
        rd_d  = pop ? nxt(rd_q) : rd_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (ack) state_d = S_HOLD;
            S_HOLD:     if (force_redir && !rein) state_d = S_REDIRECT;
                        else if (cnt_d == 4'd0)   state_d = S_IDLE;
            S_REDIRECT: if (rein)      state_d = (cnt_d == 4'd0) ? S_IDLE : S_HOLD;
                        else if (swap) state_d = S_HOLD;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || empty || (state_q == S_REDIRECT && state_d != S_REDIRECT))
            starve_d = '0;
        else if (state_q == S_HOLD && !sb.slot_free && starve_q != LIM)
            starve_d = starve_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            starve_q   <= '0;
            inject_q   <= 1'b0;
            inj_flit_q <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            starve_q   <= starve_d;
            inject_q   <= pop;
            if (pop) inj_flit_q <= mem_q[rd_q];
            redirect_q <= (state_d == S_REDIRECT);
        end
    end

    // Read of mem_q[rd_q] sees the pre-edge value, so a full-buffer swap on the same entry is safe.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= swap ? sb.chan_flit : sb.defl_flit;
    end

    assign sb.defl_ack = ack;
    assign sb.inject   = inject_q;
    assign sb.inj_flit = inj_flit_q;
    assign sb.redirect = redirect_q;
    assign sb.count    = cnt_q;
    assign sb.full     = full;
    assign sb.empty    = empty;
endmodule

// File: tb/tb_side_buffer_ctrl.sv
// Directed, table-driven bench for side_buffer_ctrl (default build, DEPTH=6, STARVE_LIM=8).
module tb_side_buffer_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    side_buffer_ctrl_if #(.FLIT_W(11)) sb();

    side_buffer_ctrl #(.FLIT_W(11), .DEPTH(6), .STARVE_LIM(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb)
    );

    typedef struct {
        bit        dv;
        bit [10:0] df;
        bit        sf;
        bit        cv;
        bit [10:0] cf;
        bit        e_ack;
        bit        e_inj;
        bit [10:0] e_flit;
        bit        e_red;
        int        e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit dv, bit [10:0] df, bit sf, bit cv, bit [10:0] cf,
                                bit ea, bit ei, bit [10:0] ef, bit er, int ec);
        vec_t v;
        v.dv = dv; v.df = df; v.sf = sf; v.cv = cv; v.cf = cf;
        v.e_ack = ea; v.e_inj = ei; v.e_flit = ef; v.e_red = er; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        sb.defl_valid = v.dv; sb.defl_flit = v.df;
        sb.slot_free  = v.sf; sb.chan_valid = v.cv; sb.chan_flit = v.cf;
    endtask

    // Drive at negedge, check combinational ack, then registered outputs just after the edge.
    task automatic run(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, "/ack"}, int'(sb.defl_ack), int'(v.e_ack));
        @(posedge clk);
        #1;
        chk({tag, "/inject"}, int'(sb.inject), int'(v.e_inj));
        if (v.e_inj) chk({tag, "/inj_flit"}, int'(sb.inj_flit), int'(v.e_flit));
        chk({tag, "/redirect"}, int'(sb.redirect), int'(v.e_red));
        chk({tag, "/count"}, int'(sb.count), v.e_cnt);
        chk({tag, "/full"}, int'(sb.full), int'(v.e_cnt == 6));
        chk({tag, "/empty"}, int'(sb.empty), int'(v.e_cnt == 0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "/count"}, int'(sb.count), 0);
        chk({tag, "/empty"}, int'(sb.empty), 1);
        chk({tag, "/full"}, int'(sb.full), 0);
        chk({tag, "/inject"}, int'(sb.inject), 0);
        chk({tag, "/inj_flit"}, int'(sb.inj_flit), 0);
        chk({tag, "/redirect"}, int'(sb.redirect), 0);
    endtask

    task automatic idle_blocked(input int n, input int cnt, input string tag);
        for (int i = 0; i < n; i++) run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, cnt), tag);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single capture / re-inject
        tbl.push_back(mk(1, 11'h155, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 11'h155, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // fill to full, 7th blocked, blocked again while popping, drain with wrap
        for (int i = 1; i <= 6; i++) tbl.push_back(mk(1, 11'(i), 0, 0, 0, 1, 0, 0, 0, i));
        tbl.push_back(mk(1, 11'h007, 0, 0, 0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 11'h0AA, 1, 0, 0, 0, 1, 11'h001, 0, 5));
        for (int i = 2; i <= 6; i++) tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 11'(i), 0, 6 - i));
        // streaming capture + re-inject
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk(1, 11'(12'h100 + k), 1, 0, 0, 1, k > 0, 11'(12'h100 + k - 1), 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 11'h113, 0, 0));

        foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i));

        // starvation with one flit, redirect beats capture, then swap
        run(mk(1, 11'h0A1, 0, 0, 0, 1, 0, 0, 0, 1), "st_cap");
        idle_blocked(8, 1, "st_wait");
        run(mk(1, 11'h0B2, 0, 0, 0, 0, 0, 0, 1, 1), "st_force");
        run(mk(1, 11'h0B3, 0, 0, 0, 0, 0, 0, 1, 1), "st_hold");
        run(mk(1, 11'h0B4, 0, 1, 11'h7FF, 0, 1, 11'h0A1, 0, 1), "st_swap");
        run(mk(0, 0, 1, 0, 0, 0, 1, 11'h7FF, 0, 0), "st_drain");

        // swap while full
        for (int i = 1; i <= 6; i++) run(mk(1, 11'(8'h10 + i), 0, 0, 0, 1, 0, 0, 0, i), "fs_fill");
        idle_blocked(3, 6, "fs_wait");
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6), "fs_force");
        run(mk(0, 0, 0, 1, 11'h3C3, 0, 1, 11'h011, 0, 6), "fs_swap");
        for (int i = 2; i <= 6; i++) run(mk(0, 0, 1, 0, 0, 0, 1, 11'(8'h10 + i), 0, 7 - i), "fs_drain");
        run(mk(0, 0, 1, 0, 0, 0, 1, 11'h3C3, 0, 0), "fs_last");

        // reset during redirect with count 3
        for (int i = 1; i <= 3; i++) run(mk(1, 11'(8'h20 + i), 0, 0, 0, 1, 0, 0, 0, i), "rr_fill");
        idle_blocked(6, 3, "rr_wait");
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3), "rr_force");
        @(negedge clk);
        drive(mk(0, 0, 1, 1, 11'h555, 0, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rr_async");
        @(posedge clk);
        #1;
        chk_reset_outs("rr_held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run(mk(0, 0, 1, 1, 11'h555, 0, 0, 0, 0, 0), "rr_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/side_buffer_ctrl.md
Name: side_buffer_ctrl

Overview:
Sequencing controller for the MinBD side buffer. Owns the side-buffer storage and decides, cycle by cycle, when a deflected flit is captured, when the head flit is re-injected into a free channel slot, and when a starving buffer forces a redirect (swap) with a channel flit. Sits between the deflection/eject stage and the injection stage of the router pipeline.

Parameters:
FLIT_W, 11, flit width in bits
DEPTH, 6, side-buffer entries; any value 2..15, not required to be a power of two
STARVE_LIM, 8, consecutive blocked cycles before a forced redirect, 1..255

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
defl_valid  in  1  deflected flit offered for capture this cycle
defl_flit  in  FLIT_W  deflected flit
defl_ack  out  1  combinational; flit taken this cycle
slot_free  in  1  injection stage has an empty channel slot this cycle
chan_valid  in  1  channel flit available for redirect
chan_flit  in  FLIT_W  channel flit to swap into the buffer
inject  out  1  registered one-cycle pulse; inj_flit is valid
inj_flit  out  FLIT_W  registered flit being re-injected
redirect  out  1  registered; controller requests a channel flit for swap
count  out  4  registered occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (async assert, sync release): count=0, rd/wr pointers=0, starve counter=0, state=IDLE, inject=0, inj_flit=0, redirect=0, empty=1, full=0. Storage contents are discarded. Reset mid-redirect abandons the swap; no flit is emitted.
- Storage: circular buffer. Pointers wrap from DEPTH-1 to 0 explicitly, not by modulo-2^n.
- Capture: defl_ack = defl_valid && !full && state!=REDIRECT. On ack, write at wr_ptr and increment wr_ptr.
- Re-inject: if state!=REDIRECT && !empty && slot_free, then next cycle inject=1 and inj_flit=head; rd_ptr advances.
- No bypass. A flit written in cycle N is eligible for re-injection from cycle N+1 at the earliest.
- Simultaneous capture and re-inject: count unchanged.
- When full, capture is blocked even if a pop occurs in the same cycle.
- Starve counter (8 bit):
  - Increments each cycle with !empty && !slot_free in HOLD.
  - Clears on any inject, on empty, and on leaving REDIRECT.
  - Saturates at STARVE_LIM.
- States:
  - IDLE (empty): on capture go to HOLD.
  - HOLD (non-empty): go to IDLE when the last flit pops and there is no same-cycle capture. Go to REDIRECT when the starve counter reaches STARVE_LIM; this takes priority over capture in that cycle.
  - REDIRECT: redirect=1 every cycle. Capture is suppressed.
    - If slot_free occurs first: normal re-inject, go to HOLD or IDLE.
    - If chan_valid occurs first: swap. Write chan_flit, pop head, inject next cycle, count unchanged (legal even when full). Then go to HOLD.
    - If slot_free && chan_valid together: re-inject takes priority and no swap occurs.
- inject never asserts in two consecutive cycles while count was 1 and no capture occurred.

Optional Feature:
SB_RANDOM_CAPTURE_EN
- Defined: adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) that advances every cycle. defl_ack additionally requires lfsr[0]==0, giving about 50% probabilistic capture.
- Undefined: no LFSR; every eligible deflected flit is captured.

Test Plan:
- Reset, then defl_valid with flit 11'h155 and slot_free=0 for 1 cycle -> defl_ack=1, count=1 next cycle. slot_free=1 in cycle 3 -> inject=1 with inj_flit=11'h155 in cycle 4, empty=1.
- Capture 6 flits 11'h001..11'h006, then a 7th, with slot_free=0 -> full=1, 7th defl_ack=0. Drain with slot_free=1 -> inject order 001..006, rd_ptr wraps, count returns to 0.
- 1 flit held, slot_free=0 for STARVE_LIM=8 cycles -> redirect=1 in cycle 9. chan_valid with flit 11'h7FF -> inject of old head next cycle, count stays 1, later drain yields 11'h7FF.
- Buffer full, forced redirect swap -> swap accepted, full stays 1, no overflow.
- Capture and slot_free every cycle for 20 cycles with streaming flits -> count steady at 1, inject every cycle after the first, order preserved.
- rst_n low during REDIRECT with count=3 -> outputs immediately at reset values, no inject after release.
